rk_kbd_sched: RTL and testbench



---
 rtl/rk_kbd_sched_pkg.sv | 28 ++
 rtl/rk_kbd_step_timer.sv | 30 +++
 rtl/rk_kbd_sched.sv | 153 +++++++++++++++
 tb/tb_rk_kbd_sched.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rk_kbd_sched_pkg.sv
// rk_kbd_pkg: shared types and constants for the keyboard matrix write scheduler.
package rk_kbd_pkg;

    // Sequencer states of the autotype script player.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_WAIT  = 2'd3
    } state_e;

    // One matrix key event; also the bit layout of a script entry.
    typedef struct packed {
        logic       press;
        logic [2:0] col;
        logic [3:0] row;
    } key_evt_t;

    localparam logic [7:0] SCR_END   = 8'hFF;
    localparam logic [7:0] SCR_PAUSE = 8'h00;
    localparam int         KBD_ROWS  = 11;

    // Rows 11..15 do not exist in the matrix and are never written.
    function automatic logic row_valid(input logic [3:0] row);
        return row < 4'(KBD_ROWS);
    endfunction

endpackage

// File: rtl/rk_kbd_step_timer.sv
// rk_kbd_step_timer: loadable down-counter that paces script entries.
// Reloads to STEP_TICKS-3 so that WAIT plus FETCH plus EXEC spans STEP_TICKS clocks.
module rk_kbd_step_timer #(
    parameter int STEP_TICKS = 3000000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam int            TW     = $clog2(STEP_TICKS + 1);
    localparam logic [TW-1:0] RELOAD = TW'(STEP_TICKS - 3);

    logic [TW-1:0] count;

    // Count down while enabled and hold at zero until the next load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (en && count != '0) begin
            count <= count - TW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rk_kbd_sched.sv
// rk_kbd_sched: arbitrates the keyboard matrix write port between live PS/2
// key events and a timed autotype script read from an external ROM.
// Build macro RK_KBD_SCHED_ABORT_EN: a live key press aborts a running script
// (clear pulse, then the press is written); without it live input stalls while busy.
module rk_kbd_sched
    import rk_kbd_pkg::*;
#(
    parameter int STEP_TICKS = 3000000,
    parameter int AW         = 6,
    parameter int BOOT_ADDR  = 1,
    parameter int RUN_ADDR   = 26
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_boot,
    input  logic          start_run,
    input  logic          live_valid,
    output logic          live_ready,
    input  logic          live_press,
    input  logic [3:0]    live_row,
    input  logic [2:0]    live_col,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic          mx_we,
    output logic [3:0]    mx_row,
    output logic [2:0]    mx_col,
    output logic          mx_val,
    output logic          mx_clr,
    output logic          busy
);
    localparam logic [1:0]    ST_IDLE   = S_IDLE;
    localparam logic [1:0]    ST_FETCH  = S_FETCH;
    localparam logic [1:0]    ST_EXEC   = S_EXEC;
    localparam logic [1:0]    ST_WAIT   = S_WAIT;
    localparam logic [AW-1:0] ADDR_LAST = '1;

    logic [1:0]    state_reg;
    key_evt_t      entry;
    logic          start_any;
    logic [AW-1:0] start_addr;
    logic          live_hs;
    logic          abort_req;
    logic          timer_zero;

    assign entry      = key_evt_t'(rom_data);
    assign start_any  = start_boot | start_run;
    // Boot wins when both starts arrive together.
    assign start_addr = start_boot ? AW'(BOOT_ADDR) : AW'(RUN_ADDR);
    assign busy       = (state_reg != ST_IDLE);
    assign live_hs    = live_valid & live_ready;

`ifdef RK_KBD_SCHED_ABORT_EN
    logic     abort_pend;
    key_evt_t pend_evt;

    // Hold off new live events only while an aborting press waits to be written.
    assign live_ready = ~abort_pend;
    assign abort_req  = live_hs & busy & live_press;

    // Capture the aborting press so it lands on the cycle after the clear pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_pend <= 1'b0;
            pend_evt   <= '0;
        end else begin
            abort_pend <= abort_req;
            if (abort_req) begin
                pend_evt <= key_evt_t'({live_press, live_col, live_row});
            end
        end
    end
`else
    assign live_ready = ~busy;
    assign abort_req  = 1'b0;
`endif

    rk_kbd_step_timer #(
        .STEP_TICKS(STEP_TICKS)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (start_any | (state_reg == ST_EXEC)),
        .en   (state_reg == ST_WAIT),
        .zero (timer_zero)
    );

    // Script sequencer, ROM address and the registered matrix write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            rom_addr  <= '0;
            mx_we     <= 1'b0;
            mx_row    <= '0;
            mx_col    <= '0;
            mx_val    <= 1'b0;
            mx_clr    <= 1'b0;
        end else begin
            mx_we  <= 1'b0;
            mx_clr <= 1'b0;
            if (start_any) begin
                // A start always (re)starts cleanly, discarding any entry in flight.
                rom_addr  <= start_addr;
                state_reg <= ST_FETCH;
                mx_clr    <= 1'b1;
            end else if (abort_req) begin
                state_reg <= ST_IDLE;
                mx_clr    <= 1'b1;
            end else begin
                case (state_reg)
                    ST_FETCH: state_reg <= ST_EXEC;
                    ST_EXEC: begin
                        if (rom_data == SCR_END) begin
                            state_reg <= ST_IDLE;
                        end else begin
                            if (rom_data != SCR_PAUSE && row_valid(entry.row)) begin
                                mx_we  <= 1'b1;
                                mx_row <= entry.row;
                                mx_col <= entry.col;
                                mx_val <= entry.press;
                            end
                            // Running off the top of the ROM ends the script; no wrap.
                            state_reg <= (rom_addr == ADDR_LAST) ? ST_IDLE : ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (timer_zero) begin
                            rom_addr  <= rom_addr + AW'(1);
                            state_reg <= ST_FETCH;
                        end
                    end
                    default: ;
                endcase
            end
            // Live writes come only from idle handshakes; the first script write
            // is at least two cycles after a start, so the port never collides.
            if (live_hs && !busy && row_valid(live_row)) begin
                mx_we  <= 1'b1;
                mx_row <= live_row;
                mx_col <= live_col;
                mx_val <= live_press;
            end
`ifdef RK_KBD_SCHED_ABORT_EN
            if (abort_pend && row_valid(pend_evt.row)) begin
                mx_we  <= 1'b1;
                mx_row <= pend_evt.row;
                mx_col <= pend_evt.col;
                mx_val <= pend_evt.press;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rk_kbd_sched.sv
// tb_rk_kbd_sched: randomized script/live scenarios checked cycle by cycle
// against an expected-output timeline built from the script timing rules.
module tb_rk_kbd_sched;
    localparam int STEP = 4;
    localparam int AW   = 6;
    localparam int BOOT = 1;
    localparam int RUN  = 26;
    localparam int MAXC = 600;
`ifdef RK_KBD_SCHED_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start_boot, start_run;
    logic          live_valid, live_ready, live_press;
    logic [3:0]    live_row;
    logic [2:0]    live_col;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          mx_we, mx_val, mx_clr, busy;
    logic [3:0]    mx_row;
    logic [2:0]    mx_col;

    logic [7:0] rom [64];
    bit         exp_busy [MAXC];
    bit         exp_clr  [MAXC];
    bit         exp_we   [MAXC];
    logic [7:0] exp_key  [MAXC];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // External script ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    rk_kbd_sched #(
        .STEP_TICKS(STEP),
        .AW        (AW),
        .BOOT_ADDR (BOOT),
        .RUN_ADDR  (RUN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start_boot(start_boot),
        .start_run (start_run),
        .live_valid(live_valid),
        .live_ready(live_ready),
        .live_press(live_press),
        .live_row  (live_row),
        .live_col  (live_col),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .mx_we     (mx_we),
        .mx_row    (mx_row),
        .mx_col    (mx_col),
        .mx_val    (mx_val),
        .mx_clr    (mx_clr),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic void clear_from(input int k0);
        for (int k = k0; k < MAXC; k++) begin
            exp_busy[k] = 1'b0;
            exp_clr[k]  = 1'b0;
            exp_we[k]   = 1'b0;
            exp_key[k]  = 8'h00;
        end
    endfunction

    // Script started so its clear is seen at cycle base: entry i executes at
    // base+1+i*STEP and its write is seen one cycle later. Returns the first
    // cycle at which busy reads low.
    function automatic int play(input int base, input int a);
        int         addr;
        int         ex;
        logic [7:0] e;
        addr = a;
        ex   = base + 1;
        exp_clr[base] = 1'b1;
        for (int i = 0; i < 64; i++) begin
            ex = base + 1 + i * STEP;
            e  = rom[addr];
            if (e == 8'hFF) break;
            if (e != 8'h00 && e[3:0] <= 4'd10) begin
                exp_we[ex + 1]  = 1'b1;
                exp_key[ex + 1] = e;
            end
            if (addr == 63) break;
            addr++;
        end
        for (int k = base; k <= ex; k++) exp_busy[k] = 1'b1;
        return ex + 1;
    endfunction

    function automatic logic [7:0] rand_entry(input bit allow_end);
        int         r;
        logic [7:0] e;
        r = int'($urandom_range(0, 99));
        e = 8'($urandom);
        if (allow_end && r < 6) begin
            e = 8'hFF;
        end else if (r < 20) begin
            e = 8'h00;
        end else if (r < 32) begin
            e[3:0] = 4'($urandom_range(11, 15));
            if (e == 8'hFF) e = 8'hFE;
        end else begin
            e[3:0] = 4'($urandom_range(0, 10));
        end
        return e;
    endfunction

    task automatic live_event(input logic p, input logic [3:0] r, input logic [2:0] c);
        @(negedge clk);
        live_valid = 1'b1;
        live_press = p;
        live_row   = r;
        live_col   = c;
        check("idle_ready", 32'(live_ready), 32'd1);
        @(negedge clk);
        live_valid = 1'b0;
        check("live_we", 32'(mx_we), 32'(r <= 4'd10));
        if (r <= 4'd10) check("live_key", 32'({mx_val, mx_col, mx_row}), 32'({p, c, r}));
        @(negedge clk);
        check("live_once", 32'(mx_we), 32'd0);
        $display("[TB] live press=%0d row=%0d col=%0d", p, r, c);
    endtask

    // smode 0=boot 1=run 2=both; lmode 0=none 1=with start 2=held while busy;
    // rst_req 0=no restart, >0 restart cycle, <0 random restart cycle.
    task automatic run_scenario(input string tag, input int smode, input int lmode,
                                input int rst_req, input bit rst_run);
        int          a1, a2, fin, rst_at, last;
        logic [7:0]  lk;
        logic [11:0] gv, ev;
        bit          hs_pend;
        a1 = (smode == 1) ? RUN : BOOT;
        a2 = rst_run ? RUN : BOOT;
        clear_from(0);
        fin    = play(0, a1);
        rst_at = (rst_req < 0) ? int'($urandom_range(1, fin - 1)) : rst_req;
        if (rst_at >= fin) rst_at = 0;
        if (rst_at > 0) begin
            clear_from(rst_at);
            fin = play(rst_at, a2);
        end
        lk = 8'($urandom);
        if (lmode == 1 && lk[3:0] <= 4'd10) begin
            exp_we[0]  = 1'b1;
            exp_key[0] = lk;
        end
        if (lmode == 2 && lk[3:0] <= 4'd10) begin
            exp_we[fin + 1]  = 1'b1;
            exp_key[fin + 1] = lk;
        end
        last = fin + 3;

        @(negedge clk);
        start_boot = (smode != 1);
        start_run  = (smode != 0);
        if (lmode == 1) begin
            live_valid = 1'b1;
            {live_press, live_col, live_row} = lk;
        end
        hs_pend = live_valid & live_ready;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            gv = {live_ready, busy, mx_clr, mx_we,
                  exp_we[k] ? {mx_val, mx_col, mx_row} : 8'h00};
            ev = {ABORT ? 1'b1 : ~exp_busy[k], exp_busy[k], exp_clr[k], exp_we[k],
                  exp_we[k] ? exp_key[k] : 8'h00};
            check($sformatf("%s@%0d rdy/busy/clr/we/key", tag, k), 32'(gv), 32'(ev));
            if (k == 0) check({tag, " start_addr"}, 32'(rom_addr), 32'(a1));
            if (rst_at > 0 && k == rst_at) check({tag, " restart_addr"}, 32'(rom_addr), 32'(a2));
            start_boot = 1'b0;
            start_run  = 1'b0;
            if (hs_pend) live_valid = 1'b0;
            if (lmode == 2 && k == 0) begin
                live_valid = 1'b1;
                {live_press, live_col, live_row} = lk;
            end
            if (rst_at > 0 && k + 1 == rst_at) begin
                start_boot = ~rst_run;
                start_run  = rst_run;
            end
            hs_pend = live_valid & live_ready;
        end
        $display("[TB] script %s: start=%0d live=%0d restart@%0d busy_end@%0d",
                 tag, smode, lmode, rst_at, fin);
    endtask

    task automatic load_directed();
        foreach (rom[i]) rom[i] = 8'hFF;
        rom[1]  = 8'hA6;
        rom[2]  = 8'h26;
        rom[3]  = 8'h00;
        rom[4]  = 8'hFF;
        rom[26] = 8'h35;
        rom[27] = 8'hFF;
    endtask

    initial begin
        reset      = 1'b1;
        start_boot = 1'b0;
        start_run  = 1'b0;
        live_valid = 1'b0;
        live_press = 1'b0;
        live_row   = 4'd0;
        live_col   = 3'd0;
        foreach (rom[i]) rom[i] = 8'hFF;
        #12;
        check("reset_outs", 32'({mx_we, mx_clr, mx_val, mx_row, mx_col, busy, rom_addr}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Idle live path, including a dropped out-of-range row.
        live_event(1'b1, 4'd2, 3'd5);
        live_event(1'b0, 4'd12, 3'd1);
        repeat (3) live_event(1'($urandom), 4'($urandom), 3'($urandom));

        load_directed();
        run_scenario("boot_directed", 0, 0, 0, 1'b0);
`ifndef RK_KBD_SCHED_ABORT_EN
        run_scenario("live_held", 0, 2, 0, 1'b0);
`endif
        run_scenario("both_then_run", 2, 0, 6, 1'b1);
        run_scenario("run_with_live", 1, 1, 0, 1'b0);

        foreach (rom[i]) rom[i] = rand_entry(1'b0);
        rom[27] = 8'h7C;
        run_scenario("no_end_marker", 1, 0, 0, 1'b0);

        for (int s = 0; s < 20; s++) begin
            foreach (rom[i]) rom[i] = rand_entry(1'b1);
            run_scenario($sformatf("rand%0d", s), int'($urandom_range(0, 2)),
                         ABORT ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2)),
                         ($urandom_range(0, 2) == 0) ? -1 : 0, 1'($urandom));
        end

        // Asynchronous reset in WAIT, then silence afterwards.
        load_directed();
        @(negedge clk);
        start_boot = 1'b1;
        @(negedge clk);
        start_boot = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_reset_outs",
                 32'({mx_we, mx_clr, mx_val, mx_row, mx_col, busy, rom_addr}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check($sformatf("post_reset@%0d we/clr/busy", k), 32'({mx_we, mx_clr, busy}), 32'd0);
        end
        $display("[TB] reset during WAIT");

`ifdef RK_KBD_SCHED_ABORT_EN
        load_directed();
        @(negedge clk);
        start_boot = 1'b1;
        @(negedge clk);
        start_boot = 1'b0;
        @(negedge clk);
        @(negedge clk);
        live_valid = 1'b1;
        live_press = 1'b1;
        live_row   = 4'd3;
        live_col   = 3'd1;
        check("abort_ready", 32'(live_ready), 32'd1);
        @(negedge clk);
        live_valid = 1'b0;
        check("abort_clr/busy/we", 32'({mx_clr, busy, mx_we}), 32'b100);
        @(negedge clk);
        check("abort_write", 32'({busy, mx_we, mx_val, mx_col, mx_row}), 32'({2'b01, 1'b1, 3'd1, 4'd3}));
        $display("[TB] abort by live press");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
